// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and load-use detection for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, LU_REP = 2'd2} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic f_load_use(input logic memrd, input logic [4:0] rt_ex,
                                      input logic [4:0] rs_id, input logic [4:0] rt_id,
                                      input logic uses_rt);
    return memrd && (rt_ex != REG_ZERO) && ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
  endfunction
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping event counter with synchronous clear over increment
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : i_inc ? r_cnt + 1'b1 : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush control for IF/ID and ID/EX with mem-wait freeze sequencing,
// performance counters and a runaway-hold watchdog
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rt_ID,
  input  logic             jump_ID,
  input  logic             MemRd_EX,
  input  logic [4:0]       rt_EX,
  input  logic             br_taken_EX,
  input  logic             JumpReg_EX,
  input  logic             mem_wait,
  input  logic             cnt_clr,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             hold_err
);
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  state_t r_state, w_next;
  logic r_lu_pend, r_hold_err;
  logic [HW-1:0] r_hold_run;
  logic w_load_use, w_ctrl_ex, w_lu_en;
  assign w_load_use = f_load_use(MemRd_EX, rt_EX, rs_ID, rt_ID, uses_rt_ID);
  assign w_ctrl_ex  = br_taken_EX | JumpReg_EX;
  // a load-use pending across a freeze is serviced by LU_REP, not on the exit cycle
  assign w_lu_en    = !(r_state == WAIT && r_lu_pend);
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      pc_hold = 1'b0;
    end else if (mem_wait) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_stall = 1'b1;
    end else if (w_ctrl_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use && w_lu_en) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (jump_ID) begin
      ifid_flush = 1'b1;
    end
    w_next = mem_wait ? WAIT : (r_state == WAIT && r_lu_pend && !w_ctrl_ex) ? LU_REP : RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= RUN;
      r_lu_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (mem_wait && r_state != WAIT) r_lu_pend <= w_load_use;
    end
  // hold_run saturates one past the limit so a long freeze cannot wrap it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hold_run <= '0;
      r_hold_err <= 1'b0;
    end else begin
      r_hold_run <= !pc_hold ? '0 : (r_hold_run > HOLD_LIM) ? r_hold_run : r_hold_run + 1'b1;
      r_hold_err <= cnt_clr ? 1'b0 : r_hold_err | (pc_hold && r_hold_run == HOLD_LIM);
    end
  assign hold_err = r_hold_err;
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .i_inc(pc_hold & idex_bubble), .i_clr(cnt_clr), .o_cnt(stall_cnt)
  );
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .i_inc(ifid_flush), .i_clr(cnt_clr), .o_cnt(flush_cnt)
  );
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_wait (
    .clk(clk), .rst(rst), .i_inc(idex_stall), .i_clr(cnt_clr), .o_cnt(wait_cnt)
  );
endmodule
